// File: rtl/regfile_ctrl_if.sv
// Bundle for the regfile_ctrl requester, response and register-file sides.
// slave = controller, master = requesters plus register-file model.
interface regfile_ctrl_if #(
  parameter int reg_width  = 5,
  parameter int data_width = 32
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [reg_width-1:0]  wr_addr;
  logic [data_width-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [reg_width-1:0]  rd_rs1;
  logic [reg_width-1:0]  rd_rs2;
  logic                  rd_use_rs2;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [data_width-1:0] resp_rs1_data;
  logic [data_width-1:0] resp_rs2_data;

  logic                  rf_rd_en;
  logic                  rf_rs1_en;
  logic                  rf_rs2_en;
  logic [reg_width-1:0]  rf_rd;
  logic [reg_width-1:0]  rf_rs1;
  logic [reg_width-1:0]  rf_rs2;
  logic [data_width-1:0] rf_rd_din;
  logic [data_width-1:0] rf_rs1_dout;
  logic [data_width-1:0] rf_rs2_dout;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_rs1, rd_rs2, rd_use_rs2,
    input  resp_ready, rf_rs1_dout, rf_rs2_dout,
    output wr_ready, rd_ready, resp_valid, resp_rs1_data, resp_rs2_data,
    output rf_rd_en, rf_rs1_en, rf_rs2_en, rf_rd, rf_rs1, rf_rs2, rf_rd_din
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_rs1, rd_rs2, rd_use_rs2,
    output resp_ready, rf_rs1_dout, rf_rs2_dout,
    input  wr_ready, rd_ready, resp_valid, resp_rs1_data, resp_rs2_data,
    input  rf_rd_en, rf_rs1_en, rf_rs2_en, rf_rd, rf_rs1, rf_rs2, rf_rd_din
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Arbitrates write and read requesters onto a one-op-per-cycle register file.
// Define REGFILE_CTRL_FWD_EN to enable write-to-read forwarding.
//
// state | meaning
// IDLE  | accept writes/reads; read wins only after max_wr_burst starving writes
// RESP  | present read response until resp_ready; writes still accepted
module regfile_ctrl #(
  parameter int reg_width    = 5,
  parameter int data_width   = 32,
  parameter int max_wr_burst = 4
) (
  input  logic          clk,
  input  logic          resetn,
  regfile_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam int STREAK_W = $clog2(max_wr_burst + 1);
  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(max_wr_burst);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [STREAK_W-1:0]   r_wr_streak;
  logic [STREAK_W-1:0]   w_wr_streak_nxt;
  logic                  r_use_rs2;
  logic                  r_resp_live;
  logic [data_width-1:0] r_resp_rs1;
  logic [data_width-1:0] r_resp_rs2;

  logic                  w_wr_addr_nz;
  logic                  w_rd_prio;
  logic                  w_wr_grant;
  logic                  w_rd_grant;
  logic                  w_fwd;
  logic [data_width-1:0] w_rs2_live;

  always_comb begin
    w_state_nxt        = r_state;
    w_wr_streak_nxt    = r_wr_streak;
    bus.wr_ready       = 1'b0;
    bus.rd_ready       = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_rs1_data  = '0;
    bus.resp_rs2_data  = '0;
    bus.rf_rd_en       = 1'b0;
    bus.rf_rs1_en      = 1'b0;
    bus.rf_rs2_en      = 1'b0;
    bus.rf_rd          = '0;
    bus.rf_rs1         = '0;
    bus.rf_rs2         = '0;
    bus.rf_rd_din      = '0;

    w_wr_addr_nz = (bus.wr_addr != {reg_width{1'b0}});
    w_rs2_live   = r_use_rs2 ? bus.rf_rs2_dout : '0;
    w_rd_prio    = (r_state == IDLE) && bus.rd_valid && (r_wr_streak == BURST_MAX);
    w_wr_grant   = resetn && bus.wr_valid && !w_rd_prio;
    w_rd_grant   = resetn && (r_state == IDLE) && bus.rd_valid && !w_wr_grant;
    w_fwd        = 1'b0;
`ifdef REGFILE_CTRL_FWD_EN
    // Every read operand is either the register being written or x0.
    w_fwd = w_wr_grant && w_wr_addr_nz && (r_state == IDLE) && bus.rd_valid &&
            ((bus.rd_rs1 == bus.wr_addr) || (bus.rd_rs1 == '0)) &&
            (!bus.rd_use_rs2 || (bus.rd_rs2 == bus.wr_addr) || (bus.rd_rs2 == '0));
`endif

    if (w_wr_grant) begin
      bus.wr_ready = 1'b1;
      if (w_wr_addr_nz) begin
        bus.rf_rd_en  = 1'b1;
        bus.rf_rd     = bus.wr_addr;
        bus.rf_rd_din = bus.wr_data;
      end
    end

    if (w_rd_grant) begin
      bus.rd_ready  = 1'b1;
      bus.rf_rs1_en = 1'b1;
      bus.rf_rs2_en = bus.rd_use_rs2;
      bus.rf_rs1    = bus.rd_rs1;
      bus.rf_rs2    = bus.rd_rs2;
      w_state_nxt   = RESP;
    end

    if (w_fwd) begin
      bus.rd_ready = 1'b1;
      w_state_nxt  = RESP;
    end

    if (resetn) begin
      case (r_state)
        IDLE: begin
          if (w_rd_grant || w_fwd || !bus.rd_valid) begin
            w_wr_streak_nxt = '0;
          end else if (w_wr_grant) begin
            w_wr_streak_nxt = r_wr_streak + 1'b1;
          end
        end
        RESP: begin
          bus.resp_valid    = 1'b1;
          bus.resp_rs1_data = r_resp_live ? bus.rf_rs1_dout : r_resp_rs1;
          bus.resp_rs2_data = r_resp_live ? w_rs2_live : r_resp_rs2;
          if (bus.resp_ready) begin
            w_state_nxt = IDLE;
          end
          if (!bus.rd_valid) begin
            w_wr_streak_nxt = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_wr_streak <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_streak <= w_wr_streak_nxt;
    end
  end

  // The register file only holds read data for one cycle guaranteed, so the
  // first RESP cycle passes it through and snapshots it for any stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_use_rs2   <= 1'b0;
      r_resp_live <= 1'b0;
      r_resp_rs1  <= '0;
      r_resp_rs2  <= '0;
    end else if (w_rd_grant) begin
      r_use_rs2   <= bus.rd_use_rs2;
      r_resp_live <= 1'b1;
    end else if (w_fwd) begin
      r_use_rs2   <= bus.rd_use_rs2;
      r_resp_live <= 1'b0;
      r_resp_rs1  <= (bus.rd_rs1 == '0) ? '0 : bus.wr_data;
      r_resp_rs2  <= (bus.rd_use_rs2 && (bus.rd_rs2 != '0)) ? bus.wr_data : '0;
    end else if ((r_state == RESP) && r_resp_live) begin
      r_resp_live <= 1'b0;
      r_resp_rs1  <= bus.rf_rs1_dout;
      r_resp_rs2  <= w_rs2_live;
    end
  end

endmodule
